// File: rtl/fb_write_sched_if.sv
// Framebuffer write scheduler bus: host pixel port, fill command port
// and the registered VRAM write port.
interface fb_write_sched_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 24
);
    logic [1:0]        res;
    logic              host_valid;
    logic              host_ready;
    logic [10:0]       host_x;
    logic [9:0]        host_y;
    logic [DATA_W-1:0] host_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [10:0]       cmd_x0;
    logic [9:0]        cmd_y0;
    logic [10:0]       cmd_w;
    logic [9:0]        cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic              fill_abort;
    logic              fill_busy;
    logic              fill_done;
    logic              fill_err;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;

    modport master (
        output res, host_valid, host_x, host_y, host_data,
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        output fill_abort,
        input  host_ready, cmd_ready, fill_busy, fill_done, fill_err,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  res, host_valid, host_x, host_y, host_data,
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        input  fill_abort,
        output host_ready, cmd_ready, fill_busy, fill_done, fill_err,
        output fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/fb_write_sched.sv
// Shares the VRAM write port between host pixel writes and a
// rectangle fill engine, round-robin under contention.
module fb_write_sched #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 24,
    parameter int WIDTH_HI  = 1280,
    parameter int HEIGHT_HI = 720,
    parameter int WIDTH_LO  = 640,
    parameter int HEIGHT_LO = 480
) (
    input logic             clk,
    input logic             rst,
    fb_write_sched_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic              prio_q;
    logic [10:0]       x0_q;
    logic [10:0]       cx_q;
    logic [9:0]        cy_q;
    logic [11:0]       xe_q;
    logic [10:0]       ye_q;
    logic [DATA_W-1:0] color_q;
    logic              hi_q;

    logic        cmd_hi;
    logic [11:0] cmd_xe;
    logic [11:0] lim_w;
    logic [10:0] cmd_ye;
    logic [10:0] lim_h;
    logic        cmd_zero;
    logic        cmd_oob;
    logic        row_end;
    logic        last_px;
    logic        start;
    logic        fill_req;
    logic        grant_host;
    logic        grant_fill;
    logic        done_d;
    logic        err_d;

    // y*stride as shift-add: 1280 = 1024+256, 640 = 512+128
    function automatic logic [ADDR_W-1:0] lin_addr(
        input logic [10:0] x,
        input logic [9:0]  y,
        input logic        hi
    );
        logic [21:0] yy;
        logic [21:0] full;
        yy = {12'd0, y};
        if (hi)
            full = (yy << 10) + (yy << 8) + {11'd0, x};
        else
            full = (yy << 9) + (yy << 7) + {11'd0, x};
        return full[ADDR_W-1:0];
    endfunction

    assign cmd_hi   = (bus.res == 2'b01);
    assign cmd_xe   = {1'b0, bus.cmd_x0} + {1'b0, bus.cmd_w};
    assign cmd_ye   = {1'b0, bus.cmd_y0} + {1'b0, bus.cmd_h};
    assign lim_w    = cmd_hi ? 12'(WIDTH_HI) : 12'(WIDTH_LO);
    assign lim_h    = cmd_hi ? 11'(HEIGHT_HI) : 11'(HEIGHT_LO);
    assign cmd_zero = (bus.cmd_w == '0) || (bus.cmd_h == '0);
    assign cmd_oob  = (cmd_xe > lim_w) || (cmd_ye > lim_h);

    assign row_end = ({1'b0, cx_q} + 12'd1) == xe_q;
    assign last_px = row_end && (({1'b0, cy_q} + 11'd1) == ye_q);

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        fill_req   = 1'b0;
        grant_host = 1'b0;
        grant_fill = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_zero) begin
                        done_d = 1'b1;
                    end else if (cmd_oob) begin
                        err_d = 1'b1;
                    end else begin
                        start   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.fill_abort)
                    state_d = IDLE;
                else
                    fill_req = 1'b1;
            end
        endcase
        // prio_q = 0 lets the host win a tie, 1 lets the fill win
        grant_host = bus.host_valid & (~fill_req | ~prio_q);
        grant_fill = fill_req & (~bus.host_valid | prio_q);
        if (grant_fill && last_px) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    assign bus.host_ready = bus.host_valid & grant_host;
    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.fill_busy  = (state_q == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q        <= 1'b0;
            bus.fb_we     <= 1'b0;
            bus.fb_addr   <= '0;
            bus.fb_data   <= '0;
            bus.fill_done <= 1'b0;
            bus.fill_err  <= 1'b0;
        end else begin
            bus.fb_we     <= grant_host | grant_fill;
            bus.fill_done <= done_d;
            bus.fill_err  <= err_d;
            if (grant_host) begin
                prio_q      <= 1'b1;
                bus.fb_addr <= lin_addr(bus.host_x, bus.host_y, cmd_hi);
                bus.fb_data <= bus.host_data;
            end else if (grant_fill) begin
                prio_q      <= 1'b0;
                bus.fb_addr <= lin_addr(cx_q, cy_q, hi_q);
                bus.fb_data <= color_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x0_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            color_q <= '0;
            hi_q    <= 1'b0;
        end else if (start) begin
            x0_q    <= bus.cmd_x0;
            cx_q    <= bus.cmd_x0;
            cy_q    <= bus.cmd_y0;
            xe_q    <= cmd_xe;
            ye_q    <= cmd_ye;
            color_q <= bus.cmd_color;
            hi_q    <= cmd_hi;
        end else if (grant_fill) begin
            if (row_end) begin
                cx_q <= x0_q;
                cy_q <= cy_q + 10'd1;
            end else begin
                cx_q <= cx_q + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_sched.sv
// Randomized and directed bench for fb_write_sched against a
// pixel-queue reference model.
module tb_fb_write_sched;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fb_write_sched_if bus ();

    fb_write_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [19:0] a;
        logic [23:0] d;
    } px_t;

    int n_checks = 0;
    int n_err    = 0;
    int n_we     = 0;

    px_t         fq[$];
    bit          prio_fill;
    bit          e_we;
    bit          e_done;
    bit          e_err;
    logic [19:0] e_addr;
    logic [23:0] e_data;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] maddr(input int x, input int y,
                                         input bit hi);
        int a;
        a = y * (hi ? 1280 : 640) + x;
        return a[19:0];
    endfunction

    task automatic model_reset();
        fq.delete();
        prio_fill = 1'b0;
        e_we      = 1'b0;
        e_done    = 1'b0;
        e_err     = 1'b0;
        e_addr    = '0;
        e_data    = '0;
    endtask

    // One clock: check the combinational outputs, predict the write,
    // then check the registered outputs just after the edge.
    task automatic step();
        bit  hreq, freq, gh, gf, idle, hi;
        int  wl, hl, x0, y0, w, h;
        px_t p;
        #1;
        idle = (fq.size() == 0);
        hreq = bus.host_valid;
        freq = !idle && !bus.fill_abort;
        gh   = hreq && (!freq || !prio_fill);
        gf   = freq && (!hreq || prio_fill);
        chk("host_ready", bus.host_ready, gh);
        chk("cmd_ready", bus.cmd_ready, idle);
        chk("fill_busy", bus.fill_busy, !idle);
        e_we   = gh || gf;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (gh) begin
            e_addr = maddr(bus.host_x, bus.host_y, bus.res == 2'b01);
            e_data = bus.host_data;
            prio_fill = 1'b1;
        end
        if (gf) begin
            p = fq.pop_front();
            e_addr = p.a;
            e_data = p.d;
            prio_fill = 1'b0;
            if (fq.size() == 0) e_done = 1'b1;
        end
        if (!idle && bus.fill_abort) fq.delete();
        if (idle && bus.cmd_valid) begin
            hi = (bus.res == 2'b01);
            wl = hi ? 1280 : 640;
            hl = hi ? 720 : 480;
            x0 = bus.cmd_x0;
            y0 = bus.cmd_y0;
            w  = bus.cmd_w;
            h  = bus.cmd_h;
            if (w == 0 || h == 0) begin
                e_done = 1'b1;
            end else if (x0 + w > wl || y0 + h > hl) begin
                e_err = 1'b1;
            end else begin
                for (int yy = y0; yy < y0 + h; yy++)
                    for (int xx = x0; xx < x0 + w; xx++) begin
                        p.a = maddr(xx, yy, hi);
                        p.d = bus.cmd_color;
                        fq.push_back(p);
                    end
            end
        end
        @(posedge clk);
        #1;
        if (bus.fb_we) n_we++;
        chk("fb_we", bus.fb_we, e_we);
        chk("fb_addr", bus.fb_addr, e_addr);
        chk("fb_data", bus.fb_data, e_data);
        chk("fill_done", bus.fill_done, e_done);
        chk("fill_err", bus.fill_err, e_err);
    endtask

    task automatic set_cmd(input int x0, input int y0, input int w,
                           input int h, input logic [23:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_x0    = 11'(x0);
        bus.cmd_y0    = 10'(y0);
        bus.cmd_w     = 11'(w);
        bus.cmd_h     = 10'(h);
        bus.cmd_color = c;
    endtask

    task automatic check_zero_outs(input string tag);
        chk({tag, "_we"}, bus.fb_we, 0);
        chk({tag, "_addr"}, bus.fb_addr, 0);
        chk({tag, "_data"}, bus.fb_data, 0);
        chk({tag, "_busy"}, bus.fill_busy, 0);
        chk({tag, "_done"}, bus.fill_done, 0);
        chk({tag, "_err"}, bus.fill_err, 0);
    endtask

    int fill_a[6] = '{650, 651, 652, 1290, 1291, 1292};

    initial begin
        int base;
        rst            = 1'b0;
        bus.res        = 2'b00;
        bus.host_valid = 1'b0;
        bus.host_x     = '0;
        bus.host_y     = '0;
        bus.host_data  = '0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_x0     = '0;
        bus.cmd_y0     = '0;
        bus.cmd_w      = '0;
        bus.cmd_h      = '0;
        bus.cmd_color  = '0;
        bus.fill_abort = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outs("reset");
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        rst = 1'b1;

        // host writes in both resolutions
        bus.res        = 2'b01;
        bus.host_valid = 1'b1;
        bus.host_x     = 11'd5;
        bus.host_y     = 10'd2;
        bus.host_data  = 24'hABCDEF;
        step();
        chk("host_hi_addr", bus.fb_addr, 2565);
        chk("host_hi_data", bus.fb_data, 24'hABCDEF);
        bus.res = 2'b00;
        step();
        chk("host_lo_addr", bus.fb_addr, 1285);
        bus.host_valid = 1'b0;
        step();
        chk("idle_we", bus.fb_we, 0);

        // uncontended fill
        set_cmd(10, 1, 3, 2, 24'h00FF00);
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("fill_addr", bus.fb_addr, fill_a[i]);
            chk("fill_done_pos", bus.fill_done, i == 5);
        end
        step();

        // same fill against a persistent host requester
        set_cmd(10, 1, 3, 2, 24'h00FF00);
        step();
        bus.cmd_valid  = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_x     = '0;
        bus.host_y     = '0;
        bus.host_data  = 24'h123456;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("alt_addr", bus.fb_addr, (i % 2 == 0) ? 0 : fill_a[i / 2]);
            chk("alt_done", bus.fill_done, i == 11);
        end
        bus.host_valid = 1'b0;
        step();

        // out of bounds and zero-size commands
        bus.res = 2'b01;
        set_cmd(1270, 0, 20, 1, 24'hFF0000);
        step();
        bus.cmd_valid = 1'b0;
        chk("oob_err", bus.fill_err, 1);
        chk("oob_we", bus.fb_we, 0);
        step();
        set_cmd(5, 5, 0, 3, 24'hFF0000);
        step();
        bus.cmd_valid = 1'b0;
        chk("zero_done", bus.fill_done, 1);
        chk("zero_we", bus.fb_we, 0);
        step();

        // abort after two pixels
        bus.res = 2'b00;
        set_cmd(0, 0, 4, 4, 24'h0000FF);
        step();
        bus.cmd_valid = 1'b0;
        base = n_we;
        step();
        step();
        bus.fill_abort = 1'b1;
        step();
        bus.fill_abort = 1'b0;
        chk("abort_ready", bus.cmd_ready, 1);
        repeat (4) step();
        chk("abort_writes", n_we - base, 2);

        // reset in the middle of a fill
        set_cmd(0, 0, 4, 4, 24'h0000FF);
        step();
        bus.cmd_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check_zero_outs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_cmd(3, 2, 2, 1, 24'h777777);
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("postrst_addr", bus.fb_addr, 1283);
        step();
        chk("postrst_addr2", bus.fb_addr, 1284);
        chk("postrst_done", bus.fill_done, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.res        = 2'($urandom_range(0, 3));
            bus.host_valid = 1'($urandom_range(0, 1));
            bus.host_x     = 11'($urandom);
            bus.host_y     = 10'($urandom);
            bus.host_data  = 24'($urandom);
            bus.fill_abort = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0)
                set_cmd($urandom_range(0, 1290), $urandom_range(0, 725),
                        $urandom_range(0, 6), $urandom_range(0, 3),
                        24'($urandom));
            else
                bus.cmd_valid = 1'b0;
            step();
        end
        bus.host_valid = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.fill_abort = 1'b0;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
